// File: rtl/flash_loader_pkg.sv
// rtl/flash_loader_pkg.sv - shared types and constants for the flash loader
package flash_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  localparam logic [7:0] FlashCmdRead = 8'h03;

  localparam logic [1:0] WrNone = 2'b00;
  localparam logic [1:0] WrByte = 2'b01;
  localparam logic [1:0] WrWord = 2'b11;

  // Bytes gathered per READ pass: a full word, or whatever tail is left.
  function automatic logic [2:0] group_bytes(input logic [24:0] remaining);
    return (remaining >= 25'd4) ? 3'd4 : remaining[2:0];
  endfunction

endpackage

// File: rtl/flash_loader_spi_shifter.sv
// rtl/flash_loader_spi_shifter.sv - SPI mode 0 shifter with divided SCLK
module flash_loader_spi_shifter #(
  parameter int unsigned Divider = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [5:0]  nbits,
  input  logic [31:0] tx_data,
  input  logic        hold,
  input  logic        miso,
  output logic        busy,
  output logic        byte_ready,
  output logic [7:0]  rx_byte,
  output logic        sclk,
  output logic        mosi
);

  localparam int unsigned CntW = (Divider > 1) ? $clog2(Divider) : 1;

  logic [CntW-1:0] div_cnt;
  logic [31:0]     tx_sh;
  logic [5:0]      bits_left;
  logic [7:0]      rx_sh;
  logic [2:0]      rx_cnt;
  logic            tick;

  assign tick = (div_cnt == CntW'(Divider - 1));

  // tx_data is left-aligned; MSB goes out on load while SCLK is still low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      tx_sh      <= '0;
      bits_left  <= '0;
      rx_sh      <= '0;
      rx_cnt     <= '0;
      busy       <= 1'b0;
      byte_ready <= 1'b0;
      rx_byte    <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
    end else begin
      byte_ready <= 1'b0;
      if (load) begin
        busy      <= 1'b1;
        tx_sh     <= tx_data << 1;
        mosi      <= tx_data[31];
        bits_left <= nbits;
        div_cnt   <= '0;
        sclk      <= 1'b0;
        rx_cnt    <= '0;
      end else if (busy && !(hold && !sclk)) begin
        if (tick) begin
          div_cnt <= '0;
          if (!sclk) begin
            sclk   <= 1'b1;
            rx_sh  <= {rx_sh[6:0], miso};
            rx_cnt <= rx_cnt + 3'd1;
            if (rx_cnt == 3'd7) begin
              rx_byte    <= {rx_sh[6:0], miso};
              byte_ready <= 1'b1;
            end
          end else begin
            sclk      <= 1'b0;
            mosi      <= tx_sh[31];
            tx_sh     <= tx_sh << 1;
            bits_left <= bits_left - 6'd1;
            if (bits_left == 6'd1) busy <= 1'b0;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/flash_loader.sv
// rtl/flash_loader.sv - boot-time copier from SPI flash (READ 0x03) into RAM over ramio
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter logic [23:0] FlashStartAddress = 24'h00_0000,
  parameter logic [31:0] RamStartAddress   = 32'h0,
  parameter int unsigned TransferByteCount = 256,
  parameter int unsigned SpiClockDivider   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_cs_n,
  output logic        ramio_enable,
  output logic [1:0]  ramio_write_type,
  output logic [2:0]  ramio_read_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic        ramio_busy
);

  localparam logic [2:0] StIdle   = ST_IDLE;
  localparam logic [2:0] StCmd    = ST_CMD;
  localparam logic [2:0] StAddr   = ST_ADDR;
  localparam logic [2:0] StRead   = ST_READ;
  localparam logic [2:0] StWrite  = ST_WRITE;
  localparam logic [2:0] StFinish = ST_FINISH;

  logic [2:0]  state;
  logic        spi_started;
  logic        wr_active;
  logic [24:0] remaining;
  logic [2:0]  grp;
  logic [1:0]  byte_idx;
  logic [2:0]  gsz;

  logic        spi_load;
  logic [5:0]  spi_nbits;
  logic [31:0] spi_tx;
  logic        spi_hold;
  logic        spi_busy;
  logic        spi_byte_ready;
  logic [7:0]  spi_rx_byte;

  assign ramio_read_type = 3'b000;
  assign gsz             = group_bytes(remaining);
  assign spi_hold        = (state == StWrite);

  // Each SPI phase loads the shifter once on entry; spi_started remembers it.
  always_comb begin
    spi_load  = 1'b0;
    spi_nbits = 6'd0;
    spi_tx    = 32'h0;
    if (!spi_started) begin
      case (state)
        StCmd: begin
          spi_load  = 1'b1;
          spi_nbits = 6'd8;
          spi_tx    = {FlashCmdRead, 24'h0};
        end
        StAddr: begin
          spi_load  = 1'b1;
          spi_nbits = 6'd24;
          spi_tx    = {FlashStartAddress, 8'h0};
        end
        StRead: begin
          spi_load  = 1'b1;
          spi_nbits = {gsz, 3'b000};
        end
        default: ;
      endcase
    end
  end

  flash_loader_spi_shifter #(
    .Divider(SpiClockDivider)
  ) u_spi (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (spi_load),
    .nbits     (spi_nbits),
    .tx_data   (spi_tx),
    .hold      (spi_hold),
    .miso      (flash_miso),
    .busy      (spi_busy),
    .byte_ready(spi_byte_ready),
    .rx_byte   (spi_rx_byte),
    .sclk      (flash_clk),
    .mosi      (flash_mosi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= StIdle;
      spi_started      <= 1'b0;
      wr_active        <= 1'b0;
      remaining        <= '0;
      grp              <= '0;
      byte_idx         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      flash_cs_n       <= 1'b1;
      ramio_enable     <= 1'b0;
      ramio_write_type <= WrNone;
      ramio_address    <= '0;
      ramio_data_in    <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            busy          <= 1'b1;
            done          <= 1'b0;
            flash_cs_n    <= 1'b0;
            remaining     <= 25'(TransferByteCount);
            ramio_address <= RamStartAddress;
            spi_started   <= 1'b0;
            state         <= StCmd;
          end
        end
        StCmd: begin
          if (!spi_started) begin
            spi_started <= 1'b1;
          end else if (!spi_busy) begin
            spi_started <= 1'b0;
            state       <= StAddr;
          end
        end
        StAddr: begin
          if (!spi_started) begin
            spi_started <= 1'b1;
          end else if (!spi_busy) begin
            spi_started <= 1'b0;
            state       <= StRead;
          end
        end
        StRead: begin
          if (!spi_started) begin
            spi_started   <= 1'b1;
            grp           <= gsz;
            byte_idx      <= 2'd0;
            ramio_data_in <= '0;
          end else begin
            if (spi_byte_ready) begin
              ramio_data_in[{byte_idx, 3'b000} +: 8] <= spi_rx_byte;
              byte_idx <= byte_idx + 2'd1;
            end
            if (!spi_busy) begin
              spi_started <= 1'b0;
              wr_active   <= 1'b0;
              state       <= StWrite;
            end
          end
        end
        StWrite: begin
          // Enable is dropped only once ramio_busy reads low a cycle after it rose.
          if (!wr_active) begin
            if (!ramio_busy) begin
              ramio_enable     <= 1'b1;
              ramio_write_type <= (grp == 3'd4) ? WrWord : WrByte;
              wr_active        <= 1'b1;
            end
          end else if (!ramio_busy) begin
            ramio_enable     <= 1'b0;
            ramio_write_type <= WrNone;
            wr_active        <= 1'b0;
            if (grp == 3'd4) begin
              ramio_address <= ramio_address + 32'd4;
              remaining     <= remaining - 25'd4;
              state         <= (remaining == 25'd4) ? StFinish : StRead;
            end else begin
              ramio_address <= ramio_address + 32'd1;
              remaining     <= remaining - 25'd1;
              ramio_data_in <= {8'h00, ramio_data_in[31:8]};
              if (remaining == 25'd1) state <= StFinish;
            end
          end
        end
        StFinish: begin
          flash_cs_n <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// tb/tb_flash_loader.sv - directed bench: three loader configs with flash and ramio models
module tb_flash_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]  start_v, busy_force, clr_v;
  logic [2:0]  busy_v, done_v, sclk_v, mosi_v, cs_v, en_v;
  logic [1:0]  wt_v   [3];
  logic [2:0]  rt_v   [3];
  logic [31:0] addr_v [3];
  logic [31:0] data_v [3];
  logic [7:0]  flash_mem [512];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned Cnt = (g == 1) ? 7 : 256;
    localparam int unsigned Div = (g == 2) ? 3 : 1;
    localparam logic [23:0] Fa  = (g == 2) ? 24'h10 : 24'h0;
    localparam logic [31:0] Ra  = (g == 2) ? 32'h100 : 32'h0;

    logic        miso = 1'b0;
    logic        prev_sclk = 1'b0;
    int          fcnt = 0;
    int          cmds = 0;
    logic [31:0] hdr = 32'h0;
    logic [23:0] faddr = 24'h0;
    int          bitn;

    logic [7:0]  ram [1024];
    logic [1:0]  bcnt = 2'd0;
    int          words = 0, bytes = 0, encs = 0, wlog_n = 0;
    logic [31:0] wlog_addr [8];
    logic [1:0]  wlog_type [8];
    logic        rbusy;
    assign rbusy = (bcnt != 2'd0) || busy_force[g];

    flash_loader #(
      .FlashStartAddress(Fa),
      .RamStartAddress  (Ra),
      .TransferByteCount(Cnt),
      .SpiClockDivider  (Div)
    ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start_v[g]),
      .busy            (busy_v[g]),
      .done            (done_v[g]),
      .flash_clk       (sclk_v[g]),
      .flash_mosi      (mosi_v[g]),
      .flash_miso      (miso),
      .flash_cs_n      (cs_v[g]),
      .ramio_enable    (en_v[g]),
      .ramio_write_type(wt_v[g]),
      .ramio_read_type (rt_v[g]),
      .ramio_address   (addr_v[g]),
      .ramio_data_in   (data_v[g]),
      .ramio_busy      (rbusy)
    );

    // SPI flash: capture cmd+addr on rising SCLK, shift data out on falling SCLK.
    always @(sclk_v[g] or cs_v[g]) begin
      if (cs_v[g]) begin
        fcnt = 0;
      end else if (sclk_v[g] && !prev_sclk) begin
        if (fcnt < 32) hdr = {hdr[30:0], mosi_v[g]};
        fcnt = fcnt + 1;
        if (fcnt == 8 && hdr[7:0] == 8'h03) cmds = cmds + 1;
        if (fcnt == 32) faddr = hdr[23:0];
      end else if (!sclk_v[g] && prev_sclk && fcnt >= 32) begin
        bitn = fcnt - 32;
        miso = flash_mem[(int'(faddr) + bitn / 8) % 512][3'(7 - bitn % 8)];
      end
      prev_sclk = sclk_v[g];
    end

    // ramio slave: accepts a write when idle, then stays busy two cycles.
    always @(posedge clk) begin
      if (clr_v[g]) begin
        for (int i = 0; i < 1024; i++) ram[i] <= 8'hEE;
        words  <= 0;
        bytes  <= 0;
        encs   <= 0;
        wlog_n <= 0;
        bcnt   <= 2'd0;
      end else begin
        if (bcnt != 2'd0) bcnt <= bcnt - 2'd1;
        if (en_v[g] && cs_v[g]) encs <= encs + 1;
        if (en_v[g] && !rbusy && wt_v[g] != 2'b00) begin
          bcnt <= 2'd2;
          if (wlog_n < 8) begin
            wlog_addr[wlog_n] <= addr_v[g];
            wlog_type[wlog_n] <= wt_v[g];
          end
          wlog_n <= wlog_n + 1;
          ram[addr_v[g][9:0]] <= data_v[g][7:0];
          if (wt_v[g] == 2'b11) begin
            ram[addr_v[g][9:0] + 10'd1] <= data_v[g][15:8];
            ram[addr_v[g][9:0] + 10'd2] <= data_v[g][23:16];
            ram[addr_v[g][9:0] + 10'd3] <= data_v[g][31:24];
            words <= words + 1;
          end else begin
            bytes <= bytes + 1;
          end
        end
      end
    end
  end

  function automatic logic [7:0] ram_byte(input int g, input int a);
    case (g)
      0:       return g_inst[0].ram[a];
      1:       return g_inst[1].ram[a];
      default: return g_inst[2].ram[a];
    endcase
  endfunction

  function automatic logic [31:0] ram_word(input int g, input int a);
    return {ram_byte(g, a + 3), ram_byte(g, a + 2), ram_byte(g, a + 1), ram_byte(g, a)};
  endfunction

  function automatic int image_mismatches(input int g, input int ra, input int fa, input int n);
    int m = 0;
    for (int i = 0; i < n; i++) if (ram_byte(g, ra + i) !== flash_mem[fa + i]) m++;
    return m;
  endfunction

  task automatic pulse_start(input int g);
    @(negedge clk);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic clear_ram(input int g);
    @(negedge clk);
    clr_v[g] = 1'b1;
    @(negedge clk);
    clr_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input string tag);
    int n = 0;
    while (!done_v[g] && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done_v[g]), 32'd1);
  endtask

  int  period, first, cmds_before, n_en, bad_sclk, bad_cs, guard;
  logic prev;

  initial begin
    for (int i = 0; i < 512; i++) flash_mem[i] = 8'(i * 37 + 11);
    flash_mem[16] = 8'hC4;
    flash_mem[17] = 8'hA9;
    flash_mem[18] = 8'hB8;
    flash_mem[19] = 8'hD5;
    rst_n = 1'b0;
    start_v = '0;
    busy_force = '0;
    clr_v = 3'b111;
    repeat (3) @(negedge clk);
    clr_v = '0;

    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_done", 32'(done_v[0]), 32'd0);
    check("rst_sclk", 32'(sclk_v[0]), 32'd0);
    check("rst_mosi", 32'(mosi_v[0]), 32'd0);
    check("rst_cs_n", 32'(cs_v[0]), 32'd1);
    check("rst_en", 32'(en_v[0]), 32'd0);
    check("rst_wt", 32'(wt_v[0]), 32'd0);
    check("rst_rt", 32'(rt_v[0]), 32'd0);
    check("rst_addr", addr_v[2], 32'd0);
    check("rst_data", data_v[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_cs_n", 32'(cs_v[0]), 32'd1);

    // Case 1: default 256-byte copy
    pulse_start(0);
    check("c1_busy_next", 32'(busy_v[0]), 32'd1);
    check("c1_cs_low_next", 32'(cs_v[0]), 32'd0);
    wait_done(0, "c1_done");
    check("c1_busy_end", 32'(busy_v[0]), 32'd0);
    check("c1_cs_end", 32'(cs_v[0]), 32'd1);
    check("c1_word16", ram_word(0, 16), 32'hD5B8A9C4);
    check("c1_word0", ram_word(0, 0), 32'h7A55300B);
    check("c1_words", 32'(g_inst[0].words), 32'd64);
    check("c1_bytes", 32'(g_inst[0].bytes), 32'd0);
    check("c1_image", 32'(image_mismatches(0, 0, 0, 256)), 32'd0);
    check("c1_en_cs_high", 32'(g_inst[0].encs), 32'd0);

    // Case 4: ramio stalled for 20 cycles while a word write is pending
    clear_ram(0);
    pulse_start(0);
    guard = 0;
    while (!(g_inst[0].words >= 10 && en_v[0]) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("c4_reach_write", 32'(en_v[0]), 32'd1);
    busy_force[0] = 1'b1;
    n_en = 0; bad_sclk = 0; bad_cs = 0;
    repeat (20) begin
      @(negedge clk);
      if (en_v[0]) n_en++;
      if (sclk_v[0]) bad_sclk++;
      if (cs_v[0]) bad_cs++;
    end
    busy_force[0] = 1'b0;
    check("c4_en_held", 32'(n_en), 32'd20);
    check("c4_sclk_low", 32'(bad_sclk), 32'd0);
    check("c4_cs_low", 32'(bad_cs), 32'd0);
    wait_done(0, "c4_done");
    check("c4_words", 32'(g_inst[0].words), 32'd64);
    check("c4_image", 32'(image_mismatches(0, 0, 0, 256)), 32'd0);

    // Case 2: 7-byte copy with a 3-byte tail
    pulse_start(1);
    wait_done(1, "c2_done");
    check("c2_words", 32'(g_inst[1].words), 32'd1);
    check("c2_bytes", 32'(g_inst[1].bytes), 32'd3);
    check("c2_w0", {g_inst[1].wlog_addr[0][29:0], g_inst[1].wlog_type[0]}, {30'd0, 2'b11});
    check("c2_w1", {g_inst[1].wlog_addr[1][29:0], g_inst[1].wlog_type[1]}, {30'd4, 2'b01});
    check("c2_w2", {g_inst[1].wlog_addr[2][29:0], g_inst[1].wlog_type[2]}, {30'd5, 2'b01});
    check("c2_w3", {g_inst[1].wlog_addr[3][29:0], g_inst[1].wlog_type[3]}, {30'd6, 2'b01});
    check("c2_word0", ram_word(1, 0), 32'h7A55300B);
    check("c2_byte4", 32'(ram_byte(1, 4)), 32'h9F);
    check("c2_byte5", 32'(ram_byte(1, 5)), 32'hC4);
    check("c2_byte6", 32'(ram_byte(1, 6)), 32'hE9);
    check("c2_byte7_kept", 32'(ram_byte(1, 7)), 32'hEE);

    // Case 3: divider 3, flash 0x10 -> RAM 0x100
    pulse_start(2);
    period = 0; first = -1; prev = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sclk_v[2] && !prev) begin
        if (first < 0) first = c;
        else if (period == 0) period = c - first;
      end
      prev = sclk_v[2];
    end
    check("c3_sclk_period", 32'(period), 32'd6);
    wait_done(2, "c3_done");
    check("c3_word100", ram_word(2, 32'h100), 32'hD5B8A9C4);
    check("c3_image", 32'(image_mismatches(2, 32'h100, 32'h10, 256)), 32'd0);

    // Case 6: start while busy is ignored; done clears on the accepted start
    cmds_before = g_inst[0].cmds;
    check("c6_done_before", 32'(done_v[0]), 32'd1);
    pulse_start(0);
    check("c6_done_cleared", 32'(done_v[0]), 32'd0);
    repeat (100) @(negedge clk);
    pulse_start(0);
    wait_done(0, "c6_done");
    check("c6_one_cmd", 32'(g_inst[0].cmds - cmds_before), 32'd1);
    repeat (5) @(negedge clk);
    check("c6_idle_after", 32'(busy_v[0]), 32'd0);

    // Case 5: reset during the address phase, then a clean re-run
    clear_ram(0);
    pulse_start(0);
    guard = 0;
    while (g_inst[0].fcnt < 12 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("c5_in_addr", 32'(g_inst[0].fcnt >= 12), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("c5_cs_n", 32'(cs_v[0]), 32'd1);
    check("c5_sclk", 32'(sclk_v[0]), 32'd0);
    check("c5_busy", 32'(busy_v[0]), 32'd0);
    check("c5_outs", {en_v[0], wt_v[0], mosi_v[0], addr_v[0][27:0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_ram(0);
    pulse_start(0);
    wait_done(0, "c5_done");
    check("c5_words", 32'(g_inst[0].words), 32'd64);
    check("c5_image", 32'(image_mismatches(0, 0, 0, 256)), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
